camera_config_sequencer: RTL and testbench

CAMERA_CONFIG_SEQUENCER -- requirements
Module: camera_config_sequencer

---
 rtl/camera_config_sequencer.sv | 112 +++++++++++
 tb/tb_camera_config_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_config_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// camera_config_sequencer: walks a register-table ROM and writes each entry over SCCB. Rev 1.0
// ---------------------------------------------------------------------------
module camera_config_sequencer #(
  parameter int CLK_FREQ = 25000000,
  parameter int DELAY_MS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  input  logic        sccb_ready,
  output logic        sccb_start,
  output logic [7:0]  sccb_address,
  output logic [7:0]  sccb_data,
  output logic        done
);

  localparam logic [31:0] DELAY_LOAD = 32'((CLK_FREQ / 1000) * DELAY_MS - 1);
  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    ISSUE     = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_IDLE = 3'd5,
    DELAY     = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t      state;
  logic [31:0] delay_cnt;
  logic        step;

  // An entry is finished either when the writer goes idle again or the delay expires.
  assign step = ((state == WAIT_IDLE) && sccb_ready) ||
                ((state == DELAY) && (delay_cnt == 32'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rom_addr     <= 8'd0;
      sccb_start   <= 1'b0;
      sccb_address <= 8'd0;
      sccb_data    <= 8'd0;
      done         <= 1'b0;
      delay_cnt    <= 32'd0;
    end else begin
      sccb_start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rom_addr <= 8'd0;
            done     <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (rom_data == END_MARK) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (rom_data == DELAY_MARK) begin
            delay_cnt <= DELAY_LOAD;
            state     <= DELAY;
          end else begin
            sccb_address <= rom_data[15:8];
            sccb_data    <= rom_data[7:0];
            state        <= ISSUE;
          end
        end
        // The pulse is raised and dropped while still in ISSUE so it never repeats.
        ISSUE: begin
          if (sccb_start) begin
            state <= WAIT_BUSY;
          end else if (sccb_ready) begin
            sccb_start <= 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (!sccb_ready) begin
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: ;
        DELAY: begin
          if (delay_cnt != 32'd0) begin
            delay_cnt <= delay_cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (step) begin
        if (rom_addr == 8'hFF) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          rom_addr <= rom_addr + 8'd1;
          state    <= FETCH;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_camera_config_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_camera_config_sequencer: ROM/writer models with a write-sequence scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
module tb_camera_config_sequencer;

  localparam int CLK_FREQ  = 1000000;
  localparam int DELAY_MS  = 2;
  localparam int DELAY_CYC = (CLK_FREQ / 1000) * DELAY_MS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_ready;
  logic        sccb_start;
  logic [7:0]  sccb_address;
  logic [7:0]  sccb_data;
  logic        done;

  always #5 clk = ~clk;

  camera_config_sequencer #(
    .CLK_FREQ(CLK_FREQ),
    .DELAY_MS(DELAY_MS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .sccb_ready(sccb_ready),
    .sccb_start(sccb_start),
    .sccb_address(sccb_address),
    .sccb_data(sccb_data),
    .done(done)
  );

  // Synchronous ROM: data follows the address one cycle later.
  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Writer model: busy for a random number of cycles after each accepted start.
  int   busy = 0;
  int   busy_min = 20;
  int   busy_max = 20;
  logic hold_low = 1'b0;
  always @(posedge clk) begin
    if (sccb_start) busy <= int'($urandom_range(busy_max, busy_min));
    else if (busy > 0) busy <= busy - 1;
  end
  assign sccb_ready = (busy == 0) && !hold_low;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  logic prev_start = 1'b0;
  int   exp_final;
  int   exp_budget;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no event within the cycle budget, required event", name);
  endtask

  // Monitor: every write pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (sccb_start) begin
      pulses++;
      check("no_back_to_back_start", prev_start, 1'b0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got write 0x%02h=0x%02h, required no write",
                 sccb_address, sccb_data);
      end else begin
        logic [15:0] w;
        w = exp_q.pop_front();
        check("sccb_address", sccb_address, w[15:8]);
        check("sccb_data", sccb_data, w[7:0]);
      end
    end
    prev_start = sccb_start;
  end

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    do w = 16'($urandom); while (w == 16'hFFFF || w == 16'hFFF0);
    return w;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  // Reference model: expected writes in table order, skipping delay markers.
  task automatic start_pass();
    int i = 0;
    int delays = 0;
    while (1) begin
      if (rom[i] == 16'hFFFF) begin
        exp_final = i;
        break;
      end
      if (rom[i] == 16'hFFF0) delays++;
      else exp_q.push_back(rom[i]);
      if (i == 255) begin
        exp_final = 255;
        break;
      end
      i++;
    end
    exp_budget = (i + 1) * (busy_max + 20) + delays * (DELAY_CYC + 20) + 200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_pass();
    int n = 0;
    while (!done && n < exp_budget) begin
      @(negedge clk);
      n++;
    end
    check("done", done, 1'b1);
    check("rom_addr_final", rom_addr, exp_final);
    check("writes_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_pulse(output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sccb_start && n < 10000);
    if (!sccb_start) fail_timeout("wait_pulse");
    t = cyc;
  endtask

  task automatic wait_ready(input logic val, output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sccb_ready !== val && n < 10000);
    if (sccb_ready !== val) fail_timeout("wait_ready");
    t = cyc;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_addr"}, rom_addr, 8'd0);
    check({tag, "_sccb_start"}, sccb_start, 1'b0);
    check({tag, "_sccb_address"}, sccb_address, 8'd0);
    check({tag, "_sccb_data"}, sccb_data, 8'd0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    int t, tr, tp, g0, g1, p0, hp;
    clear_rom();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Two writes then end marker, writer busy 20 cycles.
    rom[0] = 16'h1280; rom[1] = 16'h1100; rom[2] = 16'hFFFF;
    p0 = pulses;
    start_pass();
    wait_pulse(t);
    wait_ready(1'b0, t);
    wait_ready(1'b1, tr);
    wait_pulse(tp);
    g0 = tp - tr;
    finish_pass();
    check("two_writes_pulses", pulses - p0, 2);

    // Same writes with a delay entry between them.
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1100; rom[3] = 16'hFFFF;
    start_pass();
    wait_pulse(t);
    wait_ready(1'b0, t);
    wait_ready(1'b1, tr);
    wait_pulse(tp);
    g1 = tp - tr;
    finish_pass();
    check("delay_gap_at_least", g1 >= DELAY_CYC, 1'b1);
    check("delay_gap_extra", g1 - g0, DELAY_CYC + 2);

    // Writer held busy before the first write is issued.
    clear_rom();
    rom[0] = 16'h1234;
    hold_low = 1'b1;
    p0 = pulses;
    start_pass();
    hp = 0;
    repeat (50) begin
      @(negedge clk);
      if (sccb_start) hp++;
    end
    check("held_ready_no_pulse", hp, 0);
    hold_low = 1'b0;
    finish_pass();
    check("held_ready_pulses", pulses - p0, 1);

    // Start pulsed while a write is in flight must be ignored.
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'h3A5C; rom[2] = 16'h7701; rom[3] = 16'h4242;
    busy_min = 10; busy_max = 15;
    p0 = pulses;
    start_pass();
    wait_pulse(t);
    wait_ready(1'b0, t);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_pass();
    check("ignored_start_pulses", pulses - p0, 4);

    // Reset during WAIT_BUSY of the second write, then replay from entry 0.
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'h1100; rom[2] = 16'h2233;
    busy_min = 20; busy_max = 20;
    p0 = pulses;
    start_pass();
    wait_pulse(t);
    wait_pulse(t);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midpass_reset");
    reset = 1'b0;
    exp_q.delete();
    repeat (40) @(negedge clk);
    check("no_pulse_after_reset", pulses - p0, 2);
    start_pass();
    finish_pass();
    check("replay_pulses", pulses - p0, 5);

    // Full table of 256 writes with no end marker.
    for (int i = 0; i < 256; i++) rom[i] = rand_word();
    busy_min = 1; busy_max = 3;
    p0 = pulses;
    start_pass();
    finish_pass();
    check("full_table_pulses", pulses - p0, 256);
    repeat (5) @(negedge clk);
    check("full_table_addr_hold", rom_addr, 8'hFF);

    // Random tables with optional delay entry and random writer latency.
    for (int r = 0; r < 5; r++) begin
      int n;
      bit dly;
      clear_rom();
      n = int'($urandom_range(10, 1));
      dly = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (!dly && $urandom_range(5, 0) == 0) begin
          rom[k] = 16'hFFF0;
          dly = 1'b1;
        end else begin
          rom[k] = rand_word();
        end
      end
      busy_min = 1; busy_max = int'($urandom_range(25, 1));
      start_pass();
      finish_pass();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
